ct_had_acc_arb: RTL and testbench

- Debug-register access arbiter/sequencer in front of the per-core HAD private IR/DR decode path.
- Accepts complete register-access requests (HACR word plus data) from two requesters: req0 = JTAG-side, req1 = system-bus debug port.
- Grants them round-robin and replays each one as an ordered IR-update / DR-update pulse sequence.
- Waits for the core's completion, with a timeout, and returns a response to the owning requester.

---
 rtl/ct_had_acc_arb.sv | 221 ++++++++++++++++++++++
 tb/tb_ct_had_acc_arb.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_had_acc_arb.sv
// ct_had_acc_arb: two-requester round-robin sequencer for HAD IR/DR accesses.
// Ports: cpuclk/cpurst, ctrl_xx_dbg_disable, req0_*/req1_* request+response,
//   resp_err/resp_rdata shared response, core_* completion, arb_* update pulses.
`timescale 1ns/1ps
module ct_had_acc_arb #(
  parameter int IR_GAP  = 2,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic        cpuclk,
  input  logic        cpurst,
  input  logic        ctrl_xx_dbg_disable,
  input  logic        req0_vld,
  input  logic [15:0] req0_hacr,
  input  logic [63:0] req0_wdata,
  output logic        req0_rdy,
  output logic        req0_resp_vld,
  input  logic        req1_vld,
  input  logic [15:0] req1_hacr,
  input  logic [63:0] req1_wdata,
  output logic        req1_rdy,
  output logic        req1_resp_vld,
  output logic        resp_err,
  output logic [63:0] resp_rdata,
  input  logic        core_wr_ack,
  input  logic        core_rdata_vld,
  input  logic [63:0] core_rdata,
  output logic        arb_update_ir,
  output logic        arb_update_dr,
  output logic [63:0] arb_wdata,
  output logic        arb_busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_IR   = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_DR   = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  localparam logic [3:0]      GAP_LD  = 4'(IR_GAP - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic [2:0]      r_state;
  logic [2:0]      w_nxt;
  logic [3:0]      r_gap;
  logic [3:0]      w_gap;
  logic [TO_W-1:0] r_to;
  logic [TO_W-1:0] w_to;
  logic            r_rr;
  logic            r_own;
  // {rw, go, ex} of the granted HACR
  logic [2:0]      r_cmd;
  logic [63:0]     r_wdata;

  logic            r_ir;
  logic            r_dr;
  logic            r_rv0;
  logic            r_rv1;
  logic            r_err;
  logic            r_busy;
  logic [63:0]     r_rdata;
  logic [63:0]     r_awdata;

  logic            w_idle;
  logic            w_rdy0;
  logic            w_rdy1;
  logic            w_acc;
  logic [15:0]     w_sel_hacr;
  logic [63:0]     w_sel_wdata;
  logic            w_done;
  logic            w_ir;
  logic            w_dr;
  logic            w_resp;
  logic            w_err;
  logic [63:0]     w_rdata;
  logic [63:0]     w_awdata;

  assign w_idle = (r_state == S_IDLE) & ~ctrl_xx_dbg_disable;
  // rr_ptr only breaks ties; a lone requester always wins
  assign w_rdy0 = w_idle & req0_vld & (~req1_vld | ~r_rr);
  assign w_rdy1 = w_idle & req1_vld & (~req0_vld | r_rr);
  assign w_acc  = w_rdy0 | w_rdy1;

  assign w_sel_hacr  = w_rdy1 ? req1_hacr  : req0_hacr;
  assign w_sel_wdata = w_rdy1 ? req1_wdata : req0_wdata;

  assign w_done = r_cmd[2] ? core_rdata_vld : core_wr_ack;

  always_comb begin
    w_nxt    = r_state;
    w_gap    = r_gap;
    w_to     = r_to;
    w_ir     = 1'b0;
    w_dr     = 1'b0;
    w_resp   = 1'b0;
    w_err    = 1'b0;
    w_rdata  = 64'd0;
    w_awdata = r_awdata;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_nxt    = S_IR;
          w_ir     = 1'b1;
          w_awdata = {48'd0, w_sel_hacr};
        end
      end
      S_IR: begin
        if (ctrl_xx_dbg_disable) begin
          w_resp = 1'b1;
          w_err  = 1'b1;
        end else begin
          w_nxt = S_GAP;
          w_gap = GAP_LD;
        end
      end
      S_GAP: begin
        if (ctrl_xx_dbg_disable) begin
          w_resp = 1'b1;
          w_err  = 1'b1;
        end else if (r_gap != 4'd0) begin
          w_gap = r_gap - 4'd1;
        end else if (r_cmd[2]) begin
          w_nxt = S_WAIT;
          w_to  = '0;
        end else if (|r_cmd[1:0]) begin
          // go/ex writes expect no completion from the core
          w_resp = 1'b1;
        end else begin
          w_nxt    = S_DR;
          w_dr     = 1'b1;
          w_awdata = r_wdata;
        end
      end
      S_DR: begin
        if (ctrl_xx_dbg_disable) begin
          w_resp = 1'b1;
          w_err  = 1'b1;
        end else begin
          w_nxt = S_WAIT;
          w_to  = '0;
        end
      end
      S_WAIT: begin
        if (ctrl_xx_dbg_disable) begin
          w_resp = 1'b1;
          w_err  = 1'b1;
        end else if (w_done) begin
          // completion beats a coincident timeout
          w_resp  = 1'b1;
          w_rdata = r_cmd[2] ? core_rdata : 64'd0;
        end else if (r_to == TO_LAST) begin
          w_resp = 1'b1;
          w_err  = 1'b1;
        end else begin
          w_to = r_to + TO_ONE;
        end
      end
      S_RESP: begin
        w_nxt = S_IDLE;
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
    if (w_resp) begin
      w_nxt = S_RESP;
    end
  end

  always_ff @(posedge cpuclk) begin
    if (cpurst) begin
      r_state  <= S_IDLE;
      r_gap    <= 4'd0;
      r_to     <= '0;
      r_rr     <= 1'b0;
      r_own    <= 1'b0;
      r_cmd    <= 3'd0;
      r_wdata  <= 64'd0;
      r_ir     <= 1'b0;
      r_dr     <= 1'b0;
      r_rv0    <= 1'b0;
      r_rv1    <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_rdata  <= 64'd0;
      r_awdata <= 64'd0;
    end else begin
      r_state  <= w_nxt;
      r_gap    <= w_gap;
      r_to     <= w_to;
      r_ir     <= w_ir;
      r_dr     <= w_dr;
      r_rv0    <= w_resp & ~r_own;
      r_rv1    <= w_resp & r_own;
      r_err    <= w_err;
      r_rdata  <= w_rdata;
      r_busy   <= (w_nxt != S_IDLE);
      r_awdata <= w_awdata;
      if (w_acc) begin
        r_own   <= w_rdy1;
        r_rr    <= ~w_rdy1;
        r_cmd   <= w_sel_hacr[15:13];
        r_wdata <= w_sel_wdata;
      end
    end
  end

  assign req0_rdy      = w_rdy0;
  assign req1_rdy      = w_rdy1;
  assign req0_resp_vld = r_rv0;
  assign req1_resp_vld = r_rv1;
  assign resp_err      = r_err;
  assign resp_rdata    = r_rdata;
  assign arb_update_ir = r_ir;
  assign arb_update_dr = r_dr;
  assign arb_wdata     = r_awdata;
  assign arb_busy      = r_busy;

endmodule

// File: tb/tb_ct_had_acc_arb.sv
// tb_ct_had_acc_arb: directed + random bench for ct_had_acc_arb.
// Cycle-timeline model predicts every output; literal checks pin the model.
`timescale 1ns/1ps
module tb_ct_had_acc_arb;

  localparam int G  = 2;
  localparam int TW = 8;
  localparam int TO = 200;

  logic        cpuclk = 1'b0;
  logic        cpurst = 1'b1;
  logic        ctrl_xx_dbg_disable = 1'b0;
  logic        req0_vld = 1'b0;
  logic [15:0] req0_hacr = 16'd0;
  logic [63:0] req0_wdata = 64'd0;
  logic        req0_rdy;
  logic        req0_resp_vld;
  logic        req1_vld = 1'b0;
  logic [15:0] req1_hacr = 16'd0;
  logic [63:0] req1_wdata = 64'd0;
  logic        req1_rdy;
  logic        req1_resp_vld;
  logic        resp_err;
  logic [63:0] resp_rdata;
  logic        core_wr_ack = 1'b0;
  logic        core_rdata_vld = 1'b0;
  logic [63:0] core_rdata = 64'd0;
  logic        arb_update_ir;
  logic        arb_update_dr;
  logic [63:0] arb_wdata;
  logic        arb_busy;

  ct_had_acc_arb #(.IR_GAP(G), .TO_W(TW), .TIMEOUT(TO)) dut (
    .cpuclk              (cpuclk),
    .cpurst              (cpurst),
    .ctrl_xx_dbg_disable (ctrl_xx_dbg_disable),
    .req0_vld            (req0_vld),
    .req0_hacr           (req0_hacr),
    .req0_wdata          (req0_wdata),
    .req0_rdy            (req0_rdy),
    .req0_resp_vld       (req0_resp_vld),
    .req1_vld            (req1_vld),
    .req1_hacr           (req1_hacr),
    .req1_wdata          (req1_wdata),
    .req1_rdy            (req1_rdy),
    .req1_resp_vld       (req1_resp_vld),
    .resp_err            (resp_err),
    .resp_rdata          (resp_rdata),
    .core_wr_ack         (core_wr_ack),
    .core_rdata_vld      (core_rdata_vld),
    .core_rdata          (core_rdata),
    .arb_update_ir       (arb_update_ir),
    .arb_update_dr       (arb_update_dr),
    .arb_wdata           (arb_wdata),
    .arb_busy            (arb_busy)
  );

  always #5 cpuclk = ~cpuclk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;
  int cyc = 0;

  // transaction timeline: accepted at m_T, wait window from m_ws,
  // response cycle m_rc (pulled earlier by completion/disable)
  bit          m_act = 0;
  bit          m_rr = 0;
  bit          m_own = 0;
  bit          m_rw = 0;
  bit          m_go = 0;
  bit          m_err = 0;
  int          m_T = 0;
  int          m_ws = 0;
  int          m_rc = 0;
  logic [15:0] m_hacr = 16'd0;
  logic [63:0] m_wd = 64'd0;
  logic [63:0] m_rd = 64'd0;
  logic [63:0] m_aw = 64'd0;

  always @(negedge cpuclk) begin : cmp
    bit e_rdy0, e_rdy1, e_ir, e_dr, e_rsp, rv;
    logic [135:0] ev, av;
    if (chk_en) begin
      e_rdy0 = !m_act && !ctrl_xx_dbg_disable && req0_vld &&
               (!req1_vld || !m_rr);
      e_rdy1 = !m_act && !ctrl_xx_dbg_disable && req1_vld &&
               (!req0_vld || m_rr);
      e_ir   = m_act && (cyc == m_T + 1);
      e_dr   = m_act && !m_rw && !m_go &&
               (cyc == m_T + 2 + G) && (cyc < m_rc);
      e_rsp  = m_act && (cyc == m_rc);
      if (e_ir) m_aw = {48'd0, m_hacr};
      if (e_dr) m_aw = m_wd;
      ev = {e_rdy0, e_rdy1, e_ir, e_dr, m_act,
            e_rsp && !m_own, e_rsp && m_own, e_rsp && m_err,
            (e_rsp ? m_rd : 64'd0), m_aw};
      rv = req0_resp_vld || req1_resp_vld;
      av = {req0_rdy, req1_rdy, arb_update_ir, arb_update_dr, arb_busy,
            req0_resp_vld, req1_resp_vld, rv && resp_err,
            (rv ? resp_rdata : 64'd0), arb_wdata};
      n_chk++;
      if (av !== ev) begin
        n_err++;
        $display("FAIL outputs cyc=%0d got=%h expected=%h", cyc, av, ev);
      end
      if (cpurst) begin
        m_act = 0;
        m_rr  = 0;
        m_aw  = 64'd0;
      end else if (m_act) begin
        if (cyc == m_rc) begin
          m_act = 0;
        end else if (ctrl_xx_dbg_disable) begin
          m_rc  = cyc + 1;
          m_err = 1;
          m_rd  = 64'd0;
        end else if ((m_rw || !m_go) && cyc >= m_ws &&
                     (m_rw ? core_rdata_vld : core_wr_ack)) begin
          m_rc  = cyc + 1;
          m_err = 0;
          m_rd  = m_rw ? core_rdata : 64'd0;
        end
      end else if (e_rdy0 || e_rdy1) begin
        m_act  = 1;
        m_T    = cyc;
        m_own  = e_rdy1;
        m_rr   = !e_rdy1;
        m_hacr = e_rdy1 ? req1_hacr : req0_hacr;
        m_wd   = e_rdy1 ? req1_wdata : req0_wdata;
        m_rw   = m_hacr[15];
        m_go   = m_hacr[14] | m_hacr[13];
        m_ws   = m_rw ? cyc + 2 + G : cyc + 3 + G;
        m_rd   = 64'd0;
        if (!m_rw && m_go) begin
          m_rc  = cyc + 2 + G;
          m_err = 0;
        end else begin
          m_rc  = m_ws + TO;
          m_err = 1;
        end
      end
    end
    cyc++;
  end

  task automatic drv();
    @(posedge cpuclk);
    #1;
  endtask

  task automatic smp();
    @(negedge cpuclk);
  endtask

  task automatic lchk(input string nm, input logic [63:0] a,
                      input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic wait_acc(input bit who);
    int n = 0;
    smp();
    while (!(who ? (req1_vld && req1_rdy) : (req0_vld && req0_rdy))) begin
      if (n == 300) begin
        n_chk++;
        n_err++;
        $display("FAIL accept_timeout: got no rdy expected rdy for req%0d",
                 who);
        return;
      end
      drv();
      smp();
      n++;
    end
  endtask

  function automatic logic [15:0] rnd_hacr();
    logic [15:0] h;
    h = 16'($urandom);
    h[14] = ($urandom_range(7) == 0);
    h[13] = ($urandom_range(7) == 0);
    return h;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g[$];
    int r[$];
    int n, bad, nd, consec;
    bit prev, cur, p0, p1, a0, a1;

    // reset
    @(posedge cpuclk);
    chk_en = 1;
    #1;
    smp();
    lchk("rst_busy", arb_busy, 0);
    lchk("rst_wdata", arb_wdata, 0);
    lchk("rst_resp", {req0_resp_vld, req1_resp_vld, resp_err}, 0);
    drv(); cpurst = 0; smp();

    // write
    drv();
    req0_hacr = 16'h0D00; req0_wdata = 64'h1234; req0_vld = 1;
    wait_acc(0);
    drv(); req0_vld = 0; smp();
    lchk("wr_ir", arb_update_ir, 1);
    lchk("wr_ir_data", arb_wdata, 64'h0D00);
    drv(); smp(); drv(); smp();
    lchk("wr_gap_nodr", arb_update_dr, 0);
    drv(); smp();
    lchk("wr_dr", arb_update_dr, 1);
    lchk("wr_dr_data", arb_wdata, 64'h1234);
    drv(); smp(); drv(); smp();
    drv(); core_wr_ack = 1; smp();
    lchk("wr_noresp_yet", req0_resp_vld, 0);
    drv(); core_wr_ack = 0; smp();
    lchk("wr_resp", req0_resp_vld, 1);
    lchk("wr_resp_err", resp_err, 0);
    lchk("wr_resp_rdata", resp_rdata, 0);
    drv(); smp();
    lchk("wr_idle", arb_busy, 0);

    // read
    drv();
    req1_hacr = 16'h9300; req1_wdata = 64'h5555; req1_vld = 1;
    wait_acc(1);
    drv(); req1_vld = 0; smp();
    lchk("rd_ir_data", arb_wdata, 64'h9300);
    drv(); smp(); drv(); smp();
    drv(); core_rdata_vld = 1; core_rdata = 64'hDEADBEEF_0000CAFE; smp();
    lchk("rd_nodr", arb_update_dr, 0);
    drv(); core_rdata_vld = 0; core_rdata = 64'd0; smp();
    lchk("rd_resp", {req0_resp_vld, req1_resp_vld}, 2'b01);
    lchk("rd_rdata", resp_rdata, 64'hDEADBEEF_0000CAFE);
    lchk("rd_err", resp_err, 0);
    lchk("rd_wdata_hold", arb_wdata, 64'h9300);

    // go command
    drv();
    req0_hacr = 16'h4000; req0_wdata = 64'h77; req0_vld = 1;
    wait_acc(0);
    nd = 0;
    drv(); req0_vld = 0; smp();
    lchk("go_ir", arb_update_ir, 1);
    drv(); smp(); nd += int'(arb_update_dr);
    drv(); smp(); nd += int'(arb_update_dr);
    drv(); smp(); nd += int'(arb_update_dr);
    lchk("go_resp", req0_resp_vld, 1);
    lchk("go_err", resp_err, 0);
    lchk("go_nodr", nd, 0);

    // arbitration from reset
    drv();
    cpurst = 1; req0_vld = 1; req1_vld = 1;
    req0_hacr = 16'h4000; req1_hacr = 16'h4000;
    smp();
    drv(); cpurst = 0;
    prev = 0; consec = 0;
    for (int k = 0; k < 80; k++) begin
      smp();
      cur = (req0_rdy && req0_vld) || (req1_rdy && req1_vld);
      if (req0_rdy && req0_vld) g.push_back(0);
      if (req1_rdy && req1_vld) g.push_back(1);
      if (cur && prev) consec++;
      prev = cur;
      if (req0_resp_vld) r.push_back(0);
      if (req1_resp_vld) r.push_back(1);
      if (g.size() >= 4 && r.size() >= 4) break;
      drv();
      if (g.size() >= 4) begin req0_vld = 0; req1_vld = 0; end
    end
    lchk("arb_ngrant", g.size(), 4);
    lchk("arb_nresp", r.size(), 4);
    for (int i = 0; i < 4; i++) begin
      lchk($sformatf("arb_grant%0d", i), (i < g.size()) ? g[i] : 9, i % 2);
      lchk($sformatf("arb_resp%0d", i), (i < r.size()) ? r[i] : 9, i % 2);
    end
    lchk("arb_rdy_single", consec, 0);

    // timeout
    drv();
    req0_vld = 0; req1_vld = 0;
    req0_hacr = 16'h8000; req0_vld = 1;
    wait_acc(0);
    n = 0;
    drv(); req0_vld = 0;
    for (int k = 0; k < 400; k++) begin
      smp();
      n++;
      if (req0_resp_vld) break;
      drv();
    end
    lchk("to_latency", n, 2 + G + TO);
    lchk("to_err", resp_err, 1);
    lchk("to_rdata", resp_rdata, 0);

    // disable during GAP
    drv();
    req0_hacr = 16'h0D00; req0_wdata = 64'hABCD; req0_vld = 1;
    wait_acc(0);
    drv(); req0_vld = 0; smp();
    drv(); ctrl_xx_dbg_disable = 1; smp();
    drv(); smp();
    lchk("dis_resp", req0_resp_vld, 1);
    lchk("dis_err", resp_err, 1);
    lchk("dis_nodr", arb_update_dr, 0);
    drv(); ctrl_xx_dbg_disable = 0; smp();
    lchk("dis_nodr2", arb_update_dr, 0);
    lchk("dis_idle", arb_busy, 0);

    // disable held in IDLE
    drv();
    ctrl_xx_dbg_disable = 1; req0_hacr = 16'h0D00; req0_vld = 1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      smp();
      if (req0_rdy || arb_update_ir || arb_update_dr || arb_busy) bad++;
      drv();
    end
    req0_vld = 0; smp();
    drv(); ctrl_xx_dbg_disable = 0; smp();
    lchk("dis_idle_quiet", bad, 0);

    // reset during WAIT
    drv();
    req1_hacr = 16'h0D00; req1_wdata = 64'h99; req1_vld = 1;
    wait_acc(1);
    drv(); req1_vld = 0; smp();
    for (int k = 0; k < 4; k++) begin drv(); smp(); end
    drv(); cpurst = 1; smp();
    lchk("rst_wait_busy_before", arb_busy, 1);
    drv(); cpurst = 0; smp();
    lchk("rst_wait_busy", arb_busy, 0);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      drv(); smp();
      if (req0_resp_vld || req1_resp_vld) bad++;
    end
    lchk("rst_wait_noresp", bad, 0);

    // randomized traffic
    p0 = 0; p1 = 0; a0 = 0; a1 = 0;
    for (int k = 0; k < 3000; k++) begin
      drv();
      if (a0) begin p0 = 0; req0_vld = 0; end
      if (a1) begin p1 = 0; req1_vld = 0; end
      if (!p0 && $urandom_range(3) == 0) begin
        p0 = 1; req0_vld = 1; req0_hacr = rnd_hacr();
        req0_wdata = {$urandom, $urandom};
      end
      if (!p1 && $urandom_range(3) == 0) begin
        p1 = 1; req1_vld = 1; req1_hacr = rnd_hacr();
        req1_wdata = {$urandom, $urandom};
      end
      core_wr_ack    = ($urandom_range(5) == 0);
      core_rdata_vld = ($urandom_range(5) == 0);
      core_rdata     = {$urandom, $urandom};
      if (ctrl_xx_dbg_disable)
        ctrl_xx_dbg_disable = ($urandom_range(7) != 0);
      else
        ctrl_xx_dbg_disable = ($urandom_range(149) == 0);
      cpurst = ($urandom_range(399) == 0);
      smp();
      a0 = req0_vld && req0_rdy && !cpurst;
      a1 = req1_vld && req1_rdy && !cpurst;
    end

    // drain
    drv();
    req0_vld = 0; req1_vld = 0; core_wr_ack = 0; core_rdata_vld = 0;
    ctrl_xx_dbg_disable = 0; cpurst = 0;
    for (int k = 0; k < TO + 20; k++) begin smp(); drv(); end
    smp();
    lchk("end_idle", arb_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
